// File: rtl/gpio_debounce_pkg.sv
// Shared widths and reset level for the GPIO input path (controller, regfile, debounce).
// Synchroniser depth is selected in gpio_debounce by GPIO_DEBOUNCE_SYNC2_EN.
package gpio_debounce_pkg;

    localparam int GPIO_PIN_NUM = 16;
    localparam int DB_CNT_W     = 8;
    localparam int DB_PRE_W     = 16;

    // Level of module_rstn that holds the block in reset.
    localparam logic RST_LVL = 1'b0;

endpackage

// File: rtl/gpio_debounce_if.sv
// Pad, config and filtered-output bundle between pads/regfile and the debounce stage.
interface gpio_debounce_if
    import gpio_debounce_pkg::*;
#(
    parameter int WIDTH = GPIO_PIN_NUM,
    parameter int CNT_W = DB_CNT_W,
    parameter int PRE_W = DB_PRE_W
) ();

    logic [WIDTH-1:0] pad_in;
    logic [WIDTH-1:0] r_dben;
    logic [PRE_W-1:0] r_dbpre;
    logic [CNT_W-1:0] r_dbcnt;
    logic [WIDTH-1:0] gpio_in_filt;
    logic [WIDTH-1:0] r_dbchg;

    modport master (
        output pad_in,
        output r_dben,
        output r_dbpre,
        output r_dbcnt,
        input  gpio_in_filt,
        input  r_dbchg
    );

    modport slave (
        input  pad_in,
        input  r_dben,
        input  r_dbpre,
        input  r_dbcnt,
        output gpio_in_filt,
        output r_dbchg
    );

endinterface

// File: rtl/gpio_debounce_db_cell.sv
// One pin's glitch filter: stability counter, filtered level and change pulse.
module gpio_db_cell
    import gpio_debounce_pkg::*;
#(
    parameter int CNT_W = DB_CNT_W
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             sync_i,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] thr_i,
    output logic             filt_o,
    output logic             chg_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             chg_q, chg_d;

    // >= rather than == so a threshold lowered mid-count still lets the pin settle.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (!en_i) begin
            filt_d = sync_i;
            cnt_d  = '0;
        end else if (sync_i == filt_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q >= thr_i) begin
                filt_d = sync_i;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        chg_d = filt_d ^ filt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i == RST_LVL) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            chg_q  <= chg_d;
        end
    end

    assign filt_o = filt_q;
    assign chg_o  = chg_q;

endmodule

// File: rtl/gpio_debounce.sv
// GPIO input conditioning: pad synchroniser, shared prescaler, per-pin glitch filters.
// GPIO_DEBOUNCE_SYNC2_EN selects a two-flop synchroniser; otherwise a single capture flop.
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int WIDTH = GPIO_PIN_NUM,
    parameter int CNT_W = DB_CNT_W,
    parameter int PRE_W = DB_PRE_W
) (
    input  logic            module_clk,
    input  logic            module_rstn,
    gpio_debounce_if.slave  dbif
);

    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] chg;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick;

`ifdef GPIO_DEBOUNCE_SYNC2_EN
    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge module_clk) begin
        if (module_rstn == RST_LVL) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= dbif.pad_in;
            sync_q <= meta_q;
        end
    end
`else
    always_ff @(posedge module_clk) begin
        if (module_rstn == RST_LVL) begin
            sync_q <= '0;
        end else begin
            sync_q <= dbif.pad_in;
        end
    end
`endif

    // A divisor dropped below the running count fires on the very next cycle.
    always_comb begin
        tick      = (pre_cnt_q >= dbif.r_dbpre);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;
    end

    always_ff @(posedge module_clk) begin
        if (module_rstn == RST_LVL) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
        gpio_db_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk_i  (module_clk),
            .rstn_i (module_rstn),
            .sync_i (sync_q[gi]),
            .tick_i (tick),
            .en_i   (dbif.r_dben[gi]),
            .thr_i  (dbif.r_dbcnt),
            .filt_o (filt[gi]),
            .chg_o  (chg[gi])
        );
    end

    assign dbif.gpio_in_filt = filt;
    assign dbif.r_dbchg      = chg;

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: directed timing cases plus randomized traffic against a reference model.
module tb_gpio_debounce;
    import gpio_debounce_pkg::*;

    localparam int W  = GPIO_PIN_NUM;
    localparam int CW = DB_CNT_W;
    localparam int PW = DB_PRE_W;
`ifdef GPIO_DEBOUNCE_SYNC2_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic module_clk  = 1'b0;
    logic module_rstn = 1'b0;

    gpio_debounce_if #(.WIDTH(W), .CNT_W(CW), .PRE_W(PW)) bus ();

    gpio_debounce #(.WIDTH(W), .CNT_W(CW), .PRE_W(PW)) dut (
        .module_clk  (module_clk),
        .module_rstn (module_rstn),
        .dbif        (bus)
    );

    always #5 module_clk = ~module_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pad history for the synchroniser, tick derived from the
    // edge index of the last tick, and per pin the number of ticks seen in the
    // current unbroken mismatch run.
    logic [W-1:0] m_pipe [S];
    logic [W-1:0] m_filt = '0;
    logic [W-1:0] m_chg  = '0;
    int           m_run [W];
    int           cyc       = 0;
    int           last_tick = 0;
    bit           m_valid   = 0;

    always @(posedge module_clk) begin
        logic [W-1:0] s, nf;
        bit tk;
        cyc++;
        if (!module_rstn) begin
            for (int k = 0; k < S; k++) m_pipe[k] = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_filt    = '0;
            m_chg     = '0;
            last_tick = cyc;
            m_valid   = 1;
        end else if (m_valid) begin
            s  = m_pipe[S-1];
            tk = (cyc - last_tick - 1) >= int'(bus.r_dbpre);
            if (tk) last_tick = cyc;
            nf = m_filt;
            for (int i = 0; i < W; i++) begin
                if (!bus.r_dben[i]) begin
                    nf[i]    = s[i];
                    m_run[i] = 0;
                end else if (s[i] == m_filt[i]) begin
                    m_run[i] = 0;
                end else if (tk) begin
                    if (m_run[i] + 1 > int'(bus.r_dbcnt)) begin
                        nf[i]    = s[i];
                        m_run[i] = 0;
                    end else begin
                        m_run[i]++;
                    end
                end
            end
            m_chg  = nf ^ m_filt;
            m_filt = nf;
            for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = bus.pad_in;
        end
    end

    always @(negedge module_clk) begin
        if (m_valid) begin
            chk("model_filt", bus.gpio_in_filt, m_filt);
            chk("model_chg", bus.r_dbchg, m_chg);
        end
    end

    // Advance to n negedges later, plus 1ns: inputs change here, outputs are stable.
    task automatic adv(input int n);
        repeat (n) @(negedge module_clk);
        #1;
    endtask

    initial begin
        int t1, t2, idx;
        logic [W-1:0] mask;

        bus.pad_in  = '1;
        bus.r_dben  = '0;
        bus.r_dbpre = '0;
        bus.r_dbcnt = '0;
        module_rstn = 1'b0;
        adv(2);

        // Reset release with all pads high, pass-through.
        module_rstn = 1'b1;
        for (int m = 0; m <= S + 1; m++) begin
            adv(1);
            chk("rst_rel_filt", bus.gpio_in_filt, (m >= S) ? 32'hFFFF : 32'h0);
            chk("rst_rel_chg", bus.r_dbchg, (m == S) ? 32'hFFFF : 32'h0);
        end

        // Pin 0 step with threshold 4, tick every cycle.
        bus.pad_in = '0;
        adv(S + 3);
        bus.r_dben[0] = 1'b1;
        bus.r_dbpre   = '0;
        bus.r_dbcnt   = 8'd4;
        adv(1);
        bus.pad_in[0] = 1'b1;
        for (int m = 0; m <= S + 5; m++) begin
            adv(1);
            chk("step_filt0", bus.gpio_in_filt[0], (m >= S + 4) ? 32'h1 : 32'h0);
            chk("step_chg0", bus.r_dbchg[0], (m == S + 4) ? 32'h1 : 32'h0);
        end

        // Three-cycle glitch must be rejected.
        bus.pad_in[0] = 1'b0;
        adv(3);
        bus.pad_in[0] = 1'b1;
        for (int m = 0; m < 10; m++) begin
            adv(1);
            chk("glitch_filt0", bus.gpio_in_filt[0], 32'h1);
            chk("glitch_chg0", bus.r_dbchg[0], 32'h0);
        end
        // A full step afterwards takes the full qualification time: counter was cleared.
        bus.pad_in[0] = 1'b0;
        for (int m = 0; m <= S + 5; m++) begin
            adv(1);
            chk("post_glitch_filt0", bus.gpio_in_filt[0], (m >= S + 4) ? 32'h0 : 32'h1);
        end

        // Prescaler 3, threshold 1, pin 5.
        bus.r_dben[5] = 1'b1;
        bus.r_dbpre   = 16'd3;
        bus.r_dbcnt   = 8'd1;
        adv(1);
        t1 = -1;
        t2 = -1;
        for (int k = 0; k < 20; k++) begin
            if (dut.tick) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end
            adv(1);
        end
        chk("tick_spacing", t2 - t1, 32'd4);
        bus.pad_in[5] = 1'b1;
        idx = -1;
        for (int m = 0; m <= S + 10; m++) begin
            adv(1);
            if (bus.gpio_in_filt[5] && idx < 0) idx = m;
        end
        chk("pre_window_pin5", (idx >= S + 4 && idx <= S + 7) ? 32'h1 : 32'h0, 32'h1);

        // Threshold lowered mid-count on pin 2.
        bus.r_dben[2] = 1'b1;
        bus.r_dbpre   = '0;
        bus.r_dbcnt   = 8'd6;
        adv(1);
        bus.pad_in[2] = 1'b1;
        adv(S + 3);
        chk("midcnt_hold_filt2", bus.gpio_in_filt[2], 32'h0);
        bus.r_dbcnt = 8'd2;
        adv(1);
        chk("midcnt_filt2", bus.gpio_in_filt[2], 32'h1);
        chk("midcnt_chg2", bus.r_dbchg[2], 32'h1);

        // Reset in the middle of a qualification on pin 0.
        bus.r_dbcnt = 8'd4;
        adv(1);
        bus.pad_in[0] = 1'b1;
        adv(S + 3);
        chk("prerst_filt0", bus.gpio_in_filt[0], 32'h0);
        module_rstn = 1'b0;
        adv(1);
        chk("midrst_filt", bus.gpio_in_filt, 32'h0);
        chk("midrst_chg", bus.r_dbchg, 32'h0);
        module_rstn = 1'b1;
        for (int m = 0; m <= S + 5; m++) begin
            adv(1);
            chk("postrst_filt0", bus.gpio_in_filt[0], (m >= S + 4) ? 32'h1 : 32'h0);
        end

        // Randomized traffic; the model process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            mask = W'($urandom & $urandom & $urandom);
            bus.pad_in = bus.pad_in ^ mask;
            if ($urandom_range(49) == 0) begin
                bus.r_dben  = W'($urandom);
                bus.r_dbpre = PW'($urandom_range(4));
                bus.r_dbcnt = CW'($urandom_range(5));
            end
            module_rstn = ($urandom_range(299) != 0);
            adv(1);
        end
        module_rstn = 1'b1;
        adv(3);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/gpio_debounce.md
# gpio_debounce

Per-pin input conditioning stage between the GPIO pads and the GPIO normal-mode controller. Each of WIDTH pad inputs is synchronised into module_clk, then optionally glitch-filtered by a per-pin counter clocked by a shared prescaler tick. Its filtered output drives the controller's gpio_in, so input readback and edge/level interrupts see clean, metastability-free levels.

## Interface
- WIDTH, 16: number of pins.
- CNT_W, 8: width of the stability threshold and per-pin counters.
- PRE_W, 16: width of the prescaler divisor and counter.
- module_clk  in  1  block clock.
- module_rstn  in  1  reset; one clock, synchronous, active-low.
- pad_in  in  WIDTH  raw asynchronous pad levels.
- r_dben  in  WIDTH  per-pin filter enable; 1 = debounce, 0 = pass-through after sync.
- r_dbpre  in  PRE_W  prescaler divisor; tick period = r_dbpre+1 cycles.
- r_dbcnt  in  CNT_W  stability threshold; a change needs r_dbcnt+1 mismatching ticks.
- gpio_in_filt  out  WIDTH  filtered level to the GPIO controller; reset 0.
- r_dbchg  out  WIDTH  one-cycle pulse per pin when gpio_in_filt changes; reset 0.

## Operation
- Sync stage: per-pin flop chain, reset 0. Depth is set by the configuration macro.
- Prescaler: pre_cnt, reset 0.
  - When pre_cnt >= r_dbpre: tick=1 and pre_cnt <= 0.
  - Otherwise pre_cnt <= pre_cnt+1.
  - r_dbpre=0 gives a tick every cycle.
  - The >= compare makes a divisor lowered below the current count take effect on the next cycle. There is no full-range wrap.
- Per pin i (counter cnt[i], reset 0; filt[i] drives gpio_in_filt[i]):
  - r_dben[i]=0: filt <= sync[i]; cnt <= 0.
  - r_dben[i]=1 and sync[i]==filt: cnt <= 0. Any glitch back to the filtered level restarts qualification.
  - r_dben[i]=1, mismatch, no tick: hold.
  - r_dben[i]=1, mismatch, tick, cnt >= r_dbcnt: filt <= sync[i]; cnt <= 0.
  - r_dben[i]=1, mismatch, tick, cnt < r_dbcnt: cnt <= cnt+1.
  - The >= compare covers r_dbcnt lowered mid-count.
  - The counter never exceeds 2^CNT_W-1, because it clears at the threshold.
- r_dbchg[i] is registered on the same edge as filt: it is 1 exactly when filt[i] changes on that edge, else 0. It fires in both enable modes.
- Toggling r_dben[i] from 1 to 0 makes filt follow sync on the next edge. That step is itself a change if the levels differ, and it pulses r_dbchg.
- Toggling r_dben[i] from 0 to 1 starts with cnt=0.
- Reset asserted mid-qualification: on the next edge all flops go to 0, including the prescaler and counters. There is no r_dbchg pulse on reset.

## Timing
- Cycle numbering: pad_in changes before edge t0, and the sync output reflects it after edge t0+S-1.
  - S=2 with GPIO_DEBOUNCE_SYNC2_EN.
  - S=1 without it.
- Pass-through: gpio_in_filt updates at edge t0+S.
- Debounce with r_dbpre=0 and r_dbcnt=N: gpio_in_filt updates at edge t0+S+N. N=0 matches pass-through.
- Debounce with r_dbpre=P: the update lands on the (N+1)-th tick at or after the first mismatching cycle. Worst-case added delay is (N+1)(P+1) cycles.
- r_dbchg is high for exactly one cycle, aligned with the first cycle of the new gpio_in_filt value.
- There is no backpressure and no handshake. Config inputs are sampled every cycle.

## Configuration
- GPIO_DEBOUNCE_SYNC2_EN defined: two-flop synchroniser per pin (S=2). This is required for asynchronous pads.
- Not defined: single capture flop per pin (S=1). Use it only where pads are already synchronous to module_clk; all latencies shrink by one cycle.

## Structure
- Shared package/header: default widths (GPIO_PIN_NUM=16, DB_CNT_W=8, DB_PRE_W=16) and the reset level constant, shared with the GPIO controller and the register file.
- Top contains the sync stage, the shared prescaler and a generate loop.
- Sub-module gpio_db_cell: one pin's counter, filt and chg flops. Inputs: sync bit, tick, enable, threshold.

## Test plan
- Reset release, pad_in=16'hFFFF, r_dben=0 -> gpio_in_filt=16'h0000 until edge t0+S, then 16'hFFFF; r_dbchg=16'hFFFF for that one cycle only.
- r_dben[0]=1, r_dbpre=0, r_dbcnt=4, pad_in[0] 0->1 held -> filt[0] rises at edge t0+S+4; r_dbchg[0] pulses once.
- Same config, pad_in[0] high for 3 cycles then low -> filt[0] stays 0, r_dbchg[0] never asserts, cnt[0] back to 0.
- r_dbpre=3, r_dbcnt=1, step on pin 5 -> filt[5] changes on the 2nd tick after the mismatch, i.e. at most 8 cycles after sync; tick spacing measured as 4 cycles.
- Mid-count (cnt[2]=3, r_dbcnt=6), drive r_dbcnt=2 -> filt[2] updates on the next tick.
- Mid-count, module_rstn low for one edge -> gpio_in_filt=0, r_dbchg=0, counters cleared; qualification restarts from 0 after release.
